// File: rtl/spi_dac_receiver.sv
// -----------------------------------------------------------------------------
// spi_dac_receiver
//
// This is the receive-side model of the serial DAC write interface
// (SCK / CS_N / SDI / LDAC_N). It synchronizes the four serial pins into the
// `clock` domain and deserializes {command, data} frames into a shift register.
// A frame is checked when cs_n rises.
//
// Commands:
//   0x0       write input_code
//   0x3       write input_code and dac_code
//   all ones  software clear of both registers
//
// A falling edge on ldac_n copies input_code to dac_code.
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous, active-low reset
//   sck          serial clock from the DAC writer (asynchronous)
//   cs_n         frame select, active-low
//   sdi          serial data, MSB first, sampled on sck rising edge
//   ldac_n       load-DAC strobe, active-low, falling edge acts
//   input_code   holding register
//   dac_code     active DAC output code
//   word_valid   1-cycle pulse: good frame written to input_code
//   code_update  1-cycle pulse: dac_code reloaded (LDAC, 0x3 or clear)
//   frame_error  1-cycle pulse: wrong bit count or unknown command
//   busy         high while a frame is being shifted in
// -----------------------------------------------------------------------------
module spi_dac_receiver #(
  parameter int CMD_BITS    = 4,
  parameter int DATA_BITS   = 12,
  parameter int FRAME_BITS  = 16,   // must equal CMD_BITS + DATA_BITS
  parameter int SYNC_STAGES = 2     // >= 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 sck,
  input  logic                 cs_n,
  input  logic                 sdi,
  input  logic                 ldac_n,
  output logic [DATA_BITS-1:0] input_code,
  output logic [DATA_BITS-1:0] dac_code,
  output logic                 word_valid,
  output logic                 code_update,
  output logic                 frame_error,
  output logic                 busy
);

  // The counter must reach FRAME_BITS+1 so that over-long frames are distinct
  // from exact-length frames.
  localparam int CNT_W = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

  localparam logic [CMD_BITS-1:0] CMD_WRITE        = '0;
  localparam logic [CMD_BITS-1:0] CMD_WRITE_UPDATE = CMD_BITS'(3);
  localparam logic [CMD_BITS-1:0] CMD_CLEAR        = '1;

  // Packed pin vector layout: {ldac_n, sdi, cs_n, sck}.
  localparam int IDX_SCK  = 0;
  localparam int IDX_CS   = 1;
  localparam int IDX_SDI  = 2;
  localparam int IDX_LDAC = 3;

  // NOTE: the synchronizers reset to the idle pin levels (cs_n/ldac_n high),
  // not to zero. Resetting them to zero would fake a cs_n/ldac_n rising edge
  // right after reset.
  localparam logic [3:0] PINS_IDLE = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_CHECK
  } state_e;

  // Synchronizer chains and one-cycle delays used for edge detection.
  logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
  logic sck_dly_q, sck_dly_d;
  logic cs_dly_q, cs_dly_d;
  logic ldac_dly_q, ldac_dly_d;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0]  input_code_q, input_code_d;
  logic [DATA_BITS-1:0]  dac_code_q, dac_code_d;
  logic                  word_valid_q, word_valid_d;
  logic                  code_update_q, code_update_d;
  logic                  frame_error_q, frame_error_d;
  logic                  busy_q, busy_d;

  logic [3:0]           pins_s;
  logic                 sck_rise, cs_fall, cs_rise, ldac_fall, sdi_s;
  logic [CMD_BITS-1:0]  frame_cmd;
  logic [DATA_BITS-1:0] frame_data;

  assign pins_s     = sync_q[SYNC_STAGES-1];
  assign sdi_s      = pins_s[IDX_SDI];
  assign sck_rise   =  pins_s[IDX_SCK]  & ~sck_dly_q;
  assign cs_fall    = ~pins_s[IDX_CS]   &  cs_dly_q;
  assign cs_rise    =  pins_s[IDX_CS]   & ~cs_dly_q;
  assign ldac_fall  = ~pins_s[IDX_LDAC] &  ldac_dly_q;
  assign frame_cmd  = shreg_q[FRAME_BITS-1 -: CMD_BITS];
  assign frame_data = shreg_q[DATA_BITS-1:0];

  always_comb begin
    // NOTE: every signal assigned in this block gets a default first, so no
    // path can leave one unassigned and infer a latch.
    sync_d[0]     = {ldac_n, sdi, cs_n, sck};
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    sck_dly_d     = pins_s[IDX_SCK];
    cs_dly_d      = pins_s[IDX_CS];
    ldac_dly_d    = pins_s[IDX_LDAC];

    state_d       = state_q;
    cnt_d         = cnt_q;
    shreg_d       = shreg_q;
    input_code_d  = input_code_q;
    dac_code_d    = dac_code_q;
    word_valid_d  = 1'b0;
    code_update_d = 1'b0;
    frame_error_d = 1'b0;

    // LDAC acts in every state. A CHECK write in the same cycle overrides the
    // source below, and code_update stays a single pulse.
    if (ldac_fall) begin
      dac_code_d    = input_code_q;
      code_update_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        // sck edges are ignored here.
        if (cs_fall) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          shreg_d = '0;
        end
      end

      ST_SHIFT: begin
        if (sck_rise) begin
          // Bits beyond a full frame are dropped. The count keeps going up
          // to CNT_SAT so that the frame is still flagged as too long.
          if (cnt_q < CNT_FULL) shreg_d = {shreg_q[FRAME_BITS-2:0], sdi_s};
          if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
        end
        if (cs_rise) state_d = ST_CHECK;
      end

      ST_CHECK: begin
        state_d = ST_IDLE;
        if (cnt_q != CNT_FULL) begin
          frame_error_d = 1'b1;
        end else if (frame_cmd == CMD_WRITE) begin
          input_code_d = frame_data;
          word_valid_d = 1'b1;
          if (ldac_fall) dac_code_d = frame_data;
        end else if (frame_cmd == CMD_WRITE_UPDATE) begin
          input_code_d  = frame_data;
          dac_code_d    = frame_data;
          word_valid_d  = 1'b1;
          code_update_d = 1'b1;
        end else if (frame_cmd == CMD_CLEAR) begin
          input_code_d  = '0;
          dac_code_d    = '0;
          code_update_d = 1'b1;
        end else begin
          frame_error_d = 1'b1;
        end

        // A new frame may start back-to-back. Capture an sck edge that lands
        // in this same cycle so that the first bit is not lost.
        if (cs_fall) begin
          state_d = ST_SHIFT;
          cnt_d   = sck_rise ? CNT_W'(1) : '0;
          shreg_d = sck_rise ? FRAME_BITS'(sdi_s) : '0;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_SHIFT);
  end

  // NOTE: sequential state is updated with non-blocking assignments, so every
  // flop samples the pre-edge value of the others.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q        <= {SYNC_STAGES{PINS_IDLE}};
      sck_dly_q     <= 1'b0;
      cs_dly_q      <= 1'b1;
      ldac_dly_q    <= 1'b1;
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      shreg_q       <= '0;
      input_code_q  <= '0;
      dac_code_q    <= '0;
      word_valid_q  <= 1'b0;
      code_update_q <= 1'b0;
      frame_error_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      sck_dly_q     <= sck_dly_d;
      cs_dly_q      <= cs_dly_d;
      ldac_dly_q    <= ldac_dly_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shreg_q       <= shreg_d;
      input_code_q  <= input_code_d;
      dac_code_q    <= dac_code_d;
      word_valid_q  <= word_valid_d;
      code_update_q <= code_update_d;
      frame_error_q <= frame_error_d;
      busy_q        <= busy_d;
    end
  end

  assign input_code  = input_code_q;
  assign dac_code    = dac_code_q;
  assign word_valid  = word_valid_q;
  assign code_update = code_update_q;
  assign frame_error = frame_error_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_spi_dac_receiver.sv
// -----------------------------------------------------------------------------
// tb_spi_dac_receiver
//
// Directed and randomized frames for spi_dac_receiver.
// A behavioural model tracks:
//   - the holding code and the DAC code,
//   - the expected number of word_valid, code_update and frame_error pulses,
//   - the expected number of cycles where word_valid and code_update coincide.
// A free-running monitor counts the pulses that the DUT actually produces.
// -----------------------------------------------------------------------------
module tb_spi_dac_receiver;

  localparam int SYNC = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sck = 1'b0;
  logic        cs_n = 1'b1;
  logic        sdi = 1'b0;
  logic        ldac_n = 1'b1;
  logic [11:0] input_code;
  logic [11:0] dac_code;
  logic        word_valid;
  logic        code_update;
  logic        frame_error;
  logic        busy;

  spi_dac_receiver #(
    .CMD_BITS(4), .DATA_BITS(12), .FRAME_BITS(16), .SYNC_STAGES(SYNC)
  ) dut (
    .clock(clock), .reset(reset), .sck(sck), .cs_n(cs_n), .sdi(sdi),
    .ldac_n(ldac_n), .input_code(input_code), .dac_code(dac_code),
    .word_valid(word_valid), .code_update(code_update),
    .frame_error(frame_error), .busy(busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  // Observed pulse counts: one count per cycle that the output is high.
  int wv_cnt = 0, cu_cnt = 0, fe_cnt = 0, both_cnt = 0;
  // Expected counts and register contents from the model.
  int exp_wv = 0, exp_cu = 0, exp_fe = 0, exp_both = 0;
  logic [11:0] m_in = '0;
  logic [11:0] m_dac = '0;

  always @(negedge clock) begin
    if (reset) begin
      if (word_valid) wv_cnt++;
      if (code_update) cu_cnt++;
      if (frame_error) fe_cnt++;
      if (word_valid && code_update) both_cnt++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Lower cs_n and shift nbits of word, MSB first. cs_n stays low afterwards.
  task automatic shift_bits(input logic [31:0] word, input int nbits);
    cs_n = 1'b0;
    tick(3);
    for (int i = nbits - 1; i >= 0; i--) begin
      sdi = word[i];
      tick(2);
      sck = 1'b1;
      tick(3);
      sck = 1'b0;
      tick(1);
    end
    tick(2);
  endtask

  // Apply the frame rules to the model state.
  // with_ldac marks an LDAC edge that lands in the same cycle as the frame
  // check.
  task automatic model_frame(input logic [31:0] word, input int nbits, input bit with_ldac);
    logic [3:0]  cmd;
    logic [11:0] data;
    cmd  = word[15:12];
    data = word[11:0];
    if (nbits != 16 || !(cmd inside {4'h0, 4'h3, 4'hF})) begin
      exp_fe++;
      if (with_ldac) begin
        m_dac = m_in;
        exp_cu++;
      end
    end else if (cmd == 4'h0) begin
      m_in = data;
      exp_wv++;
      if (with_ldac) begin
        m_dac = data;
        exp_cu++;
        exp_both++;
      end
    end else if (cmd == 4'h3) begin
      m_in  = data;
      m_dac = data;
      exp_wv++;
      exp_cu++;
      exp_both++;
    end else begin
      m_in  = '0;
      m_dac = '0;
      exp_cu++;
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".input_code"}, 32'(input_code), 32'(m_in));
    check({tag, ".dac_code"}, 32'(dac_code), 32'(m_dac));
    check({tag, ".word_valid_n"}, wv_cnt, exp_wv);
    check({tag, ".code_update_n"}, cu_cnt, exp_cu);
    check({tag, ".frame_error_n"}, fe_cnt, exp_fe);
    check({tag, ".wv_cu_same_n"}, both_cnt, exp_both);
  endtask

  // Send one frame. With with_ldac set, ldac_n falls one clock after cs_n
  // rises. Both pins then pass through the same synchronizer depth, so the
  // LDAC edge is seen in the CHECK cycle.
  task automatic run_frame(input string tag, input logic [31:0] word, input int nbits,
                           input bit with_ldac);
    shift_bits(word, nbits);
    cs_n = 1'b1;
    tick(1);
    if (with_ldac) ldac_n = 1'b0;
    tick(SYNC + 4);
    ldac_n = 1'b1;
    tick(4);
    model_frame(word, nbits, with_ldac);
    check_state(tag);
  endtask

  task automatic ldac_pulse(input string tag);
    ldac_n = 1'b0;
    tick(8);              // held low: only the falling edge may act
    ldac_n = 1'b1;
    tick(4);
    m_dac = m_in;
    exp_cu++;
    check_state(tag);
  endtask

  initial begin
    logic [31:0] w;
    logic [3:0]  cmd;
    int          nbits;
    int          sel;
    bit          wl;

    // ---- reset ----
    #1 reset = 1'b0;
    tick(3);
    check("rst.input_code", 32'(input_code), 32'h0);
    check("rst.dac_code", 32'(dac_code), 32'h0);
    check("rst.word_valid", 32'(word_valid), 32'h0);
    check("rst.code_update", 32'(code_update), 32'h0);
    check("rst.frame_error", 32'(frame_error), 32'h0);
    check("rst.busy", 32'(busy), 32'h0);
    reset = 1'b1;
    tick(20);
    check_state("idle");

    // ---- 0x0ABC: exact CHECK latency, then LDAC latency ----
    shift_bits(32'h0ABC, 16);
    check("f0abc.busy_shift", 32'(busy), 32'h1);
    cs_n = 1'b1;
    tick(SYNC + 1);
    check("f0abc.wv_early", 32'(word_valid), 32'h0);
    tick(1);
    check("f0abc.wv_at_check", 32'(word_valid), 32'h1);
    check("f0abc.in_at_check", 32'(input_code), 32'hABC);
    check("f0abc.dac_hold", 32'(dac_code), 32'h0);
    tick(1);
    check("f0abc.wv_one_cycle", 32'(word_valid), 32'h0);
    check("f0abc.busy_done", 32'(busy), 32'h0);
    model_frame(32'h0ABC, 16, 1'b0);
    tick(4);
    check_state("f0abc");

    ldac_n = 1'b0;
    tick(SYNC);
    check("ldac.dac_early", 32'(dac_code), 32'h0);
    tick(1);
    check("ldac.dac_loaded", 32'(dac_code), 32'hABC);
    check("ldac.code_update", 32'(code_update), 32'h1);
    tick(6);
    ldac_n = 1'b1;
    tick(4);
    m_dac = m_in;
    exp_cu++;
    check_state("ldac");

    // ---- immediate update, bad lengths, unknown command, clear ----
    run_frame("f3123", 32'h3123, 16, 1'b0);
    run_frame("len15", 32'h0456, 15, 1'b0);
    run_frame("len17", 32'h0CDEF, 17, 1'b0);
    run_frame("f5fff", 32'h5FFF, 16, 1'b0);
    run_frame("ff000", 32'hF000, 16, 1'b0);

    // ---- LDAC coincident with CHECK ----
    run_frame("f07ff_ldac", 32'h07FF, 16, 1'b1);

    // ---- reset mid-frame ----
    run_frame("pre_rst", 32'h3321, 16, 1'b0);
    shift_bits(32'h00A5, 8);
    reset = 1'b0;
    #1;
    check("midrst.input_code", 32'(input_code), 32'h0);
    check("midrst.dac_code", 32'(dac_code), 32'h0);
    check("midrst.busy", 32'(busy), 32'h0);
    m_in  = '0;
    m_dac = '0;
    cs_n = 1'b1;
    sck  = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(5);
    run_frame("f0055", 32'h0055, 16, 1'b0);

    // ---- randomized frames ----
    for (int n = 0; n < 40; n++) begin
      sel   = $urandom_range(0, 9);
      nbits = (sel == 0) ? 15 : (sel == 1) ? 17 : 16;
      case ($urandom_range(0, 3))
        0:       cmd = 4'h0;
        1:       cmd = 4'h3;
        2:       cmd = 4'hF;
        default: begin
          cmd = 4'($urandom_range(1, 14));
          if (cmd == 4'h3) cmd = 4'h4;
        end
      endcase
      w = $urandom;
      if (nbits == 16) w = {16'h0, cmd, w[11:0]};
      else if (nbits == 15) w = w & 32'h7FFF;
      else w = w & 32'h1FFFF;
      wl = ($urandom_range(0, 3) == 0);
      run_frame($sformatf("rnd%0d", n), w, nbits, wl);
      if ($urandom_range(0, 2) == 0) ldac_pulse($sformatf("rnd%0d.ldac", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_dac_receiver.md
Name: spi_dac_receiver

Overview:
- Receive-side model of the serial DAC write interface (SCK/CS/SDI/LDAC) that the DFB, DFBM and TEC DAC writers drive.
- Deserializes command+data frames, holds an input register, and transfers it to the output code on an LDAC strobe or an immediate-update command.
- Used on-chip for DAC-path loopback and self-test. It also serves as the synthesizable DAC model in system benches.

Parameters:
CMD_BITS, 4, command field width (frame MSBs)
DATA_BITS, 12, DAC code width (frame LSBs)
FRAME_BITS, 16, bits per frame; must equal CMD_BITS+DATA_BITS
SYNC_STAGES, 2, synchronizer depth on sck/cs_n/sdi/ldac_n (>=2)

Ports:
clock  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-low reset
sck  in  1  serial clock from DAC writer (asynchronous to clock)
cs_n  in  1  frame select, active-low
sdi  in  1  serial data, MSB first, sampled on sck rising edge
ldac_n  in  1  load-DAC strobe, active-low, falling edge acts
input_code  out  DATA_BITS  input (holding) register
dac_code  out  DATA_BITS  active DAC output code
word_valid  out  1  one-cycle pulse when a good frame is written to input_code
code_update  out  1  one-cycle pulse when dac_code changes source (load event)
frame_error  out  1  one-cycle pulse on malformed or unknown frame
busy  out  1  high while in SHIFT state

Behaviour:
- Reset (reset=0, async):
  - input_code=0, dac_code=0, all pulses 0, busy=0, state IDLE, bit counter 0.
  - Synchronizer flops preset to idle levels: sck=0, cs_n=1, sdi=0, ldac_n=1.
- Synchronization and edge detection:
  - Each input passes through a SYNC_STAGES flop chain. Edges are detected on the synchronized value and its one-cycle delay.
  - sck must have a high and a low time each >= 2 clock periods.
- States:
  - IDLE: on cs_n falling edge -> SHIFT, clear counter and shift register.
  - SHIFT: each sck rising edge shifts sdi into the shift register LSB and increments the counter. The counter saturates at FRAME_BITS+1. Bits after FRAME_BITS are discarded.
  - SHIFT: on cs_n rising edge -> CHECK.
  - CHECK (1 cycle), then -> IDLE:
    - counter != FRAME_BITS -> frame_error, no register change.
    - cmd=0x0 -> input_code<=data, word_valid.
    - cmd=0x3 -> input_code<=data, dac_code<=data, word_valid and code_update in the same cycle.
    - cmd=0xF -> software clear: input_code<=0, dac_code<=0, code_update. No word_valid.
    - any other cmd -> frame_error, no change.
- LDAC:
  - A synchronized ldac_n falling edge sets dac_code<=input_code and pulses code_update. This happens in any state.
  - LDAC in the same cycle as a CHECK write: dac_code takes the newly written data, and a single code_update pulse is issued.
  - LDAC held low is level-insensitive; only the falling edge acts.
- Latency:
  - cs_n rise at pin -> CHECK outputs in SYNC_STAGES+2 clocks.
  - ldac_n fall at pin -> dac_code update in SYNC_STAGES+1 clocks.
- sck edges while in IDLE are ignored.
- cs_n falling edge during CHECK is honoured: the state enters SHIFT on the next cycle and the first sck edge is not lost.
- Reset asserted mid-frame: partial frame discarded, outputs return to reset values immediately.

Test Plan:
- Reset low: all outputs 0, busy=0. Release reset, 20 idle clocks: no pulses.
- Frame 0x0ABC (cmd 0), then LDAC pulse:
  - At CHECK: input_code=0xABC, word_valid=1 for 1 cycle, dac_code stays 0.
  - After the LDAC edge: dac_code=0xABC, code_update=1 for 1 cycle.
- Frame 0x3123: input_code=dac_code=0x123, word_valid and code_update pulse in the same cycle, no LDAC needed.
- Truncated frame (15 sck edges, then cs_n high): frame_error=1 for one cycle, and input_code/dac_code keep prior values.
  - Repeat with 17 edges: same error, same retention.
- Frame 0x5FFF (unknown cmd): frame_error, no change. Then frame 0xF000: input_code=dac_code=0, code_update.
- Frame 0x07FF with ldac_n fall aligned so its synchronized edge coincides with CHECK: dac_code=0x7FF, exactly one code_update pulse.
- Drop reset mid-frame after 8 bits, release, then send 0x0055: input_code=0x055, no frame_error.
